// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and the result type for the pipelined adder.
// The optional overflow port is controlled by `define PIPELINED_ADDER_OVERFLOW_EN.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 64;
  localparam int DEFAULT_STAGES = 4;

  typedef struct packed {
    logic                     c_out;
    logic [DEFAULT_WIDTH-1:0] sum;
  } result_t;

endpackage

// File: rtl/adder_stage.sv
// One pipeline slice: adds chunk IDX using the carry registered by the previous slice
// and forwards operands, partial result and carry alongside a valid bit.
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_WIDTH / DEFAULT_STAGES,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic             valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic [CHUNK:0]   chunkSum;
  logic             load;

  assign load = !valid_q || ready_i;

  always_comb begin
    chunkSum = {1'b0, a_i[IDX*CHUNK +: CHUNK]} + {1'b0, b_i[IDX*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_i};
    sum_d = sum_i;
    sum_d[IDX*CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
  end

  // Data only moves with a real beat, so a stalled result stays put and bubbles cost no toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      valid_q <= valid_i;
      if (valid_i) begin
        a_q     <= a_i;
        b_q     <= b_i;
        sum_q   <= sum_d;
        carry_q <= chunkSum[CHUNK];
      end
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor with valid/ready flow control on both sides.
// Define PIPELINED_ADDER_OVERFLOW_EN to add the signed overflow output.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH=%0d must be >=2 and divisible by STAGES=%0d (1..WIDTH)",
           WIDTH, STAGES);
  end

  logic [WIDTH-1:0]  opA [STAGES+1];
  logic [WIDTH-1:0]  opB [STAGES+1];
  logic [WIDTH-1:0]  res [STAGES+1];
  logic              carry [STAGES+1];
  logic [STAGES:0]   vld;
  logic [STAGES-1:0] downReady;
  logic              unusedTail;

  assign vld[0]   = in_valid;
  assign opA[0]   = a;
  assign opB[0]   = b ^ {WIDTH{sub}};
  assign res[0]   = '0;
  assign carry[0] = c_in;

  // A slice can hand off when the sink is ready or any slice further down has a hole.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_last
      assign downReady[k] = out_ready;
    end else begin : g_mid
      assign downReady[k] = out_ready || !(&vld[STAGES:k+2]);
    end

    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (vld[k]),
      .ready_i (downReady[k]),
      .a_i     (opA[k]),
      .b_i     (opB[k]),
      .sum_i   (res[k]),
      .carry_i (carry[k]),
      .valid_o (vld[k+1]),
      .a_o     (opA[k+1]),
      .b_o     (opB[k+1]),
      .sum_o   (res[k+1]),
      .carry_o (carry[k+1])
    );
  end

  assign in_ready  = !vld[1] || downReady[0];
  assign out_valid = vld[STAGES];
  assign sum       = res[STAGES];
  assign c_out     = carry[STAGES];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign overflow = opA[STAGES][WIDTH-1] ^ opB[STAGES][WIDTH-1]
                  ^ res[STAGES][WIDTH-1] ^ carry[STAGES];
`endif

  assign unusedTail = ^{opA[STAGES], opB[STAGES]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard testbench for pipelined_adder (WIDTH=64, STAGES=4).
// Overflow is also checked when PIPELINED_ADDER_OVERFLOW_EN is defined.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  typedef struct {
    result_t     res;
    logic        ovf;
    int unsigned cyc;
  } expT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  int          checks = 0;
  int          errors = 0;
  int unsigned cycle = 0;
  expT         sb[$];
  int unsigned fireLog[$];
  bit          latencyCheck = 1'b0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .sum       (sum),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic expT model(input logic [WIDTH-1:0] av, bv, input logic ci, sv);
    expT          e;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   t;
    bx = bv ^ {WIDTH{sv}};
    t = {1'b0, av} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
    e.res.c_out = t[WIDTH];
    e.res.sum   = t[WIDTH-1:0];
    e.ovf       = (av[WIDTH-1] == bx[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
    e.cyc       = 0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare on each output transfer, push on each input acceptance.
  always @(negedge clk) begin
    expT e;
    if (rst_n && out_valid && out_ready) begin
      fireLog.push_back(cycle);
      if (sb.size() == 0) begin
        checkOutput("queueOccupancy", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("sum", sum, e.res.sum);
        checkOutput("cOut", {63'd0, c_out}, {63'd0, e.res.c_out});
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        checkOutput("overflow", {63'd0, overflow}, {63'd0, e.ovf});
`endif
        if (latencyCheck) checkOutput("latency", 64'(cycle - e.cyc), 64'(STAGES));
      end
    end
    if (rst_n && in_valid && in_ready) begin
      e = model(a, b, c_in, sub);
      e.cyc = cycle;
      sb.push_back(e);
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance or after maxWait cycles.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, bv, input logic ci, sv,
                               input int maxWait, output bit accepted);
    a = av; b = bv; c_in = ci; sub = sv; in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < maxWait && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit          acc;
    int          nAcc;
    int          logStart;
    logic [63:0] bpA [6];
    logic [63:0] bpB [6];
    expT         first;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #3;
    checkOutput("resetOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("resetSum", sum, 64'd0);
    checkOutput("resetCOut", {63'd0, c_out}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("releaseInReady", {63'd0, in_ready}, 64'd1);
    checkOutput("releaseOutValid", {63'd0, out_valid}, 64'd0);

    $display("[TB] carry ripple and subtract");
    latencyCheck = 1'b1;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 4, acc);
    checkOutput("rippleAccepted", {63'd0, acc}, 64'd1);
    applyStimulus(64'd10, 64'd3, 1'b1, 1'b1, 4, acc);
    applyStimulus(64'd3, 64'd10, 1'b1, 1'b1, 4, acc);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4, acc);
    applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 4, acc);
    in_valid = 1'b0;
    waitDrain(20);

    $display("[TB] backpressure");
    latencyCheck = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bpA[i] = 64'h1111_0000_0000_0000 * (i + 1) + 64'(i);
      bpB[i] = 64'h0F0F_0F0F_0F0F_0F0F ^ 64'(i * 7);
    end
    out_ready = 1'b0;
    nAcc = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(bpA[i], bpB[i], i[0], i[1], 3, acc);
      if (acc) nAcc++;
    end
    checkOutput("bpAcceptCount", 64'(nAcc), 64'd4);
    checkOutput("bpInReady", {63'd0, in_ready}, 64'd0);
    first = model(bpA[0], bpB[0], 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("stallOutValid", {63'd0, out_valid}, 64'd1);
      checkOutput("stallSum", sum, first.res.sum);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    logStart = fireLog.size();
    applyStimulus(bpA[4], bpB[4], 1'b0, 1'b0, 10, acc);
    checkOutput("bpRetryAccepted", {63'd0, acc}, 64'd1);
    applyStimulus(bpA[5], bpB[5], 1'b1, 1'b0, 10, acc);
    in_valid = 1'b0;
    waitDrain(30);
    checkOutput("bpEmitted", 64'(fireLog.size() - logStart), 64'd6);

    $display("[TB] throughput");
    latencyCheck = 1'b1;
    logStart = fireLog.size();
    for (int i = 0; i < 100; i++) begin
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1, acc);
      if (!acc) checkOutput("tpAccepted", {63'd0, acc}, 64'd1);
    end
    in_valid = 1'b0;
    waitDrain(30);
    checkOutput("tpCount", 64'(fireLog.size() - logStart), 64'd100);
    if (fireLog.size() - logStart == 100)
      checkOutput("tpSpan", 64'(fireLog[fireLog.size()-1] - fireLog[logStart]), 64'd99);

    $display("[TB] reset mid-flight");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(64'(i + 100), 64'(i), 1'b0, 1'b0, 4, acc);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("preResetOutValid", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("midResetSum", sum, 64'd0);
    checkOutput("midResetCOut", {63'd0, c_out}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postResetInReady", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("noStaleBeat", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(64'd5, 64'd9, 1'b0, 1'b0, 4, acc);
    in_valid = 1'b0;
    waitDrain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
